csa_tree_pipe: RTL
==================

// Module: csa_tree_pipe
// PURPOSE
//  Pipelined, parametrised carry-save compressor tree for the BLAKE G-function datapath.
//  Reduces NOPS operands of WIDTH bits (mod 2^WIDTH) to a carry-save pair (vs, vc) using
//  3:2 compressor levels, with a register after every level.
//  Optionally resolves the pair to a binary sum in one extra stage.
//  Carries a valid bit and a tag with each operand set, so hash-pipeline slots stay aligned.
// PARAMETERS
//  WIDTH    32  operand width; all arithmetic is mod 2^WIDTH
//  NOPS     4   operand count, legal 3..6 (elaboration error outside this range)
//  RESOLVE  1   1 = add final stage out_sum = vs+vc; 0 = out_sum tied 0, no extra stage
//  TAG_W    8   width of sideband tag passed alongside data
// PORTS
//  clk        in   1            rising-edge clock
//  reset      in   1            asynchronous, active-high reset
//  ce         in   1            pipeline advance enable; 0 = every register holds
//  in_valid   in   1            operand set valid (sampled only when ce=1)
//  in_tag     in   TAG_W        sideband tag for this operand set
//  in_ops     in   NOPS*WIDTH   operand k = in_ops[k*WIDTH +: WIDTH]
//  out_valid  out  1            output set valid
//  out_tag    out  TAG_W        tag aligned with outputs
//  out_vs     out  WIDTH        carry-save sum word
//  out_vc     out  WIDTH        carry-save carry word, bit 0 always 0
//  out_sum    out  WIDTH        (out_vs+out_vc) mod 2^WIDTH when RESOLVE=1, else 0
// BEHAVIOUR
//  - 3:2 cell: vs = x^y^z; vc = {maj(x,y,z)[WIDTH-2:0], 1'b0}; the maj MSB is discarded (mod 2^W).
//  - Level grouping is fixed. Operands are taken in order and grouped in triples from index 0.
//    Each triple emits (vs, vc) in that order. Leftover operands (1 or 2) pass through unchanged,
//    appended after the compressor outputs.
//  - Levels L: NOPS=3->1, 4->2, 5->3, 6->3. The last level always holds exactly two words (vs, vc).
//  - Every level output is registered. Latency = L + RESOLVE cycles of ce=1 from input to output.
//  - valid and tag shift with the data through every stage; they are never reordered or dropped.
//  - ce=0: all data, valid and tag registers hold; the outputs stay stable; inputs are ignored.
//  - in_valid=0 with ce=1: a bubble is inserted (valid=0). Data registers may still load, but
//    out_vs, out_vc and out_sum are don't-care whenever out_valid=0.
//  - RESOLVE=1: the final stage registers out_vs, out_vc and the sum of the incoming pair
//    together, so out_sum = out_vs + out_vc always holds on a valid cycle.
//  - RESOLVE=0: out_vs and out_vc come straight from the level-L registers; out_sum = 0.
//  - Reset asserted (any time, including mid-stream): all valid bits, data, tag and output
//    registers clear to 0 immediately. In-flight sets are lost. First valid output appears
//    L+RESOLVE ce-cycles after the first post-reset in_valid.
//  - Throughput: one operand set per ce=1 cycle. No backpressure beyond ce.
//  - Invariant on every valid output: out_vs + out_vc == sum(in_ops) mod 2^WIDTH.
// TESTING
//  1. NOPS=3, RESOLVE=1, ops 1,2,3, tag 0x5A, ce=1 -> after 2 cycles out_valid=1,
//     out_vs=0, out_vc=6, out_sum=6, tag 0x5A.
//  2. NOPS=4, ops FFFFFFFF x4 -> out_sum=FFFFFFFC after 3 cycles, out_vc[0]=0 (wrap/MSB drop).
//  3. NOPS=6, stream 10 random sets back-to-back with in_valid pattern 1101101111 -> outputs
//     appear after 4 cycles in the same order, bubbles preserved, sum invariant holds, tags match.
//  4. ce toggled 0/1 pseudo-randomly during a stream -> out_valid and data freeze while ce=0;
//     no set is duplicated or lost; latency counts only ce=1 cycles.
//  5. Assert reset with 3 sets in flight -> out_valid=0, all outputs 0 asynchronously.
//     After release, the next set appears after exactly L+RESOLVE cycles.
//  6. NOPS=5, RESOLVE=0, ops 7,7,7,7,7 -> after 3 cycles out_vs+out_vc=35 (0x23), out_sum=0.

Source files
------------

// File: rtl/csa_tree_pipe_if.sv
// csa_tree_pipe_if: operand-set input and carry-save/sum result bundle for csa_tree_pipe
interface csa_tree_pipe_if #(
    parameter int WIDTH = 32,
    parameter int NOPS  = 4,
    parameter int TAG_W = 8
);
    logic                  ce;
    logic                  in_valid;
    logic [TAG_W-1:0]      in_tag;
    logic [NOPS*WIDTH-1:0] in_ops;
    logic                  out_valid;
    logic [TAG_W-1:0]      out_tag;
    logic [WIDTH-1:0]      out_vs;
    logic [WIDTH-1:0]      out_vc;
    logic [WIDTH-1:0]      out_sum;

    modport master (
        output ce, in_valid, in_tag, in_ops,
        input  out_valid, out_tag, out_vs, out_vc, out_sum
    );

    modport slave (
        input  ce, in_valid, in_tag, in_ops,
        output out_valid, out_tag, out_vs, out_vc, out_sum
    );
endinterface

// File: rtl/csa_tree_pipe.sv
// csa_tree_pipe: pipelined 3:2 carry-save tree reducing NOPS words to (vs, vc), optional final add
module csa_tree_pipe #(
    parameter int WIDTH   = 32,
    parameter int NOPS    = 4,
    parameter int RESOLVE = 1,
    parameter int TAG_W   = 8
) (
    input logic             clk,
    input logic             reset,
    csa_tree_pipe_if.slave  bus
);
    function automatic int next_cnt(input int n);
        return 2 * (n / 3) + n % 3;
    endfunction

    function automatic int cnt_at(input int l);
        int n = NOPS;
        for (int i = 0; i < l; i++) n = next_cnt(n);
        return n;
    endfunction

    function automatic int n_levels();
        int n = NOPS;
        int l = 0;
        while (n > 2) begin
            n = next_cnt(n);
            l++;
        end
        return l;
    endfunction

    localparam int L = n_levels();

    if (NOPS < 3 || NOPS > 6) begin : g_bad
        $error("csa_tree_pipe: NOPS must be in 3..6");
    end

    // Level 0 is the raw input; level l>0 is the register after the l-th compressor row.
    for (genvar l = 0; l <= L; l++) begin : g_lv
        localparam int N = cnt_at(l);
        logic [WIDTH-1:0] w [N];
        logic             v;
        logic [TAG_W-1:0] t;
        if (l == 0) begin : g_in
            for (genvar j = 0; j < N; j++) begin : g_w
                assign w[j] = bus.in_ops[j*WIDTH +: WIDTH];
            end
            assign v = bus.in_valid;
            assign t = bus.in_tag;
        end else begin : g_reg
            localparam int P = cnt_at(l - 1);
            localparam int T = P / 3;
            logic [WIDTH-1:0] d [N];
            for (genvar j = 0; j < N; j++) begin : g_w
                if (j < 2 * T) begin : g_c
                    logic [WIDTH-1:0] x, y, z;
                    assign x = g_lv[l-1].w[3*(j/2)];
                    assign y = g_lv[l-1].w[3*(j/2)+1];
                    assign z = g_lv[l-1].w[3*(j/2)+2];
                    // Carry word shifts left; the majority MSB falls off (mod 2^WIDTH).
                    assign d[j] = (j % 2 == 0) ? x ^ y ^ z : ((x & y) | (x & z) | (y & z)) << 1;
                end else begin : g_p
                    assign d[j] = g_lv[l-1].w[3*T + j - 2*T];
                end
            end
            always_ff @(posedge clk or posedge reset)
                if (reset) begin
                    v <= 1'b0;
                    t <= '0;
                    w <= '{default: '0};
                end else if (bus.ce) begin
                    v <= g_lv[l-1].v;
                    t <= g_lv[l-1].t;
                    w <= d;
                end
        end
    end

    if (RESOLVE != 0) begin : g_res
        always_ff @(posedge clk or posedge reset)
            if (reset) begin
                bus.out_valid <= 1'b0;
                bus.out_tag   <= '0;
                bus.out_vs    <= '0;
                bus.out_vc    <= '0;
                bus.out_sum   <= '0;
            end else if (bus.ce) begin
                bus.out_valid <= g_lv[L].v;
                bus.out_tag   <= g_lv[L].t;
                bus.out_vs    <= g_lv[L].w[0];
                bus.out_vc    <= g_lv[L].w[1];
                bus.out_sum   <= g_lv[L].w[0] + g_lv[L].w[1];
            end
    end else begin : g_raw
        assign bus.out_valid = g_lv[L].v;
        assign bus.out_tag   = g_lv[L].t;
        assign bus.out_vs    = g_lv[L].w[0];
        assign bus.out_vc    = g_lv[L].w[1];
        assign bus.out_sum   = '0;
    end
endmodule
